// File: rtl/conv_pkg.sv
// Shared types and frame-size helpers for the systolic-array feed path.
package conv_pkg;

  localparam int PIX_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOAD,
    WAIT_FEED,
    FEED,
    DRAIN,
    DONE
  } state_e;

  function automatic int npix(input int size);
    return size * size;
  endfunction

  function automatic int nfeed(input int size);
    return (size - 2) * size;
  endfunction

endpackage

// File: rtl/conv_feed_ctrl_win_counter.sv
// Wrapping column/row window counter; holds at the final position until cleared.
module win_counter #(
  parameter int COLS = 7,
  parameter int ROWS = 5,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         last
);

  assign last = (row == W'(ROWS - 1)) && (col == W'(COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en && !last) begin
      if (col == W'(COLS - 1)) begin
        col <= '0;
        row <= row + W'(1);
      end else begin
        col <= col + W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_feed_ctrl.sv
// Frame sequencer: loads one SIZE x SIZE frame into the 3-row feeder, then
// times the column stream and SA drain and reports done/underrun to the host.
module conv_feed_ctrl
  import conv_pkg::*;
#(
  parameter int SIZE      = 7,
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    pix_vld,
  input  logic signed [PIX_W-1:0] pix_data,
  output logic                    pix_rdy,
  output logic                    feed_load,
  output logic signed [PIX_W-1:0] feed_pix,
  input  logic                    feed_srt,
  output logic                    sa_en,
  output logic [7:0]              win_row,
  output logic [7:0]              win_col
);

  localparam logic [CNT_W-1:0] NPIX     = CNT_W'(npix(SIZE));
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(npix(SIZE) - 1);
  localparam logic [CNT_W-1:0] NFEED    = CNT_W'(nfeed(SIZE));
  localparam logic [CNT_W-1:0] LAST_DRN = CNT_W'(DRAIN_CYC - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] pix_cnt, feed_cnt, drn_cnt;
  logic             feeding, count_en, feed_hit, win_last;
  logic             pix_take, underrun, load_last, start_ok, clr;

  // The feed counter is independent of the load progress: it may start
  // while pixels are still arriving, as soon as the feeder has 3 rows.
  assign feeding   = (state == LOAD) || (state == WAIT_FEED) || (state == FEED);
  assign count_en  = feeding && (feed_srt || (feed_cnt != '0)) && (feed_cnt < NFEED);
  assign feed_hit  = count_en && win_last;

  assign pix_rdy   = (state == LOAD);
  assign pix_take  = pix_rdy && pix_vld;
  assign underrun  = pix_rdy && !pix_vld;
  assign load_last = pix_take && (pix_cnt == LAST_PIX);
  assign start_ok  = (state == IDLE) && start && !abort;
  assign clr       = (state_nxt == IDLE);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign feed_load = busy && (state != DONE);
  assign sa_en     = count_en || (state == DRAIN);
  assign feed_pix  = pix_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_ok) state_nxt = ARM;
      ARM:       state_nxt = LOAD;
      LOAD: begin
        if (underrun) state_nxt = IDLE;
        else if (load_last) begin
          if (feed_hit)                state_nxt = DRAIN;
          else if (feed_cnt == NFEED)  state_nxt = FEED;
          else                         state_nxt = WAIT_FEED;
        end
      end
      WAIT_FEED: if (feed_hit) state_nxt = DRAIN;
      FEED:      state_nxt = DRAIN;
      DRAIN:     if (drn_cnt == LAST_DRN) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      feed_cnt <= '0;
      drn_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      if (clr)                                pix_cnt <= '0;
      else if (pix_take && (pix_cnt != NPIX)) pix_cnt <= pix_cnt + CNT_W'(1);

      if (clr)           feed_cnt <= '0;
      else if (count_en) feed_cnt <= feed_cnt + CNT_W'(1);

      if (state != DRAIN)        drn_cnt <= '0;
      else if (drn_cnt != '1)    drn_cnt <= drn_cnt + CNT_W'(1);

      // Underrun wins over an abort in the same cycle so the host still sees it.
      if (underrun)      err <= 1'b1;
      else if (start_ok) err <= 1'b0;
    end
  end

  win_counter #(
    .COLS (SIZE),
    .ROWS (SIZE - 2),
    .W    (8)
  ) u_win (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (count_en),
    .row   (win_row),
    .col   (win_col),
    .last  (win_last)
  );

endmodule

// File: tb/tb_conv_feed_ctrl.sv
// Directed frame scenarios with randomized timing/data, checked against a
// timeline model derived from the frame rules (cycle t counted from start).
module tb_conv_feed_ctrl;

  localparam int SIZE   = 7;
  localparam int DRN    = 4;
  localparam int NPIX   = SIZE * SIZE;
  localparam int NFEED  = (SIZE - 2) * SIZE;
  localparam int BIG    = 1 << 30;

  logic               clk = 1'b0;
  logic               rst_n, start, abort, pix_vld, feed_srt;
  logic signed [15:0] pix_data;
  logic               busy, done, err, pix_rdy, feed_load, sa_en;
  logic signed [15:0] feed_pix;
  logic [7:0]         win_row, win_col;

  int n_cmp = 0;
  int n_bad = 0;
  int done_total = 0;
  bit err_m = 1'b0;

  always #5 clk = ~clk;

  conv_feed_ctrl #(.SIZE(SIZE), .DRAIN_CYC(DRN), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pix_vld   (pix_vld),
    .pix_data  (pix_data),
    .pix_rdy   (pix_rdy),
    .feed_load (feed_load),
    .feed_pix  (feed_pix),
    .feed_srt  (feed_srt),
    .sa_en     (sa_en),
    .win_row   (win_row),
    .win_col   (win_col)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input int t, input int e_busy, input int e_load, input int e_rdy,
                             input int e_sa, input int e_done, input int e_row, input int e_col);
    chk($sformatf("busy@%0d", t),      int'(busy),      e_busy);
    chk($sformatf("feed_load@%0d", t), int'(feed_load), e_load);
    chk($sformatf("pix_rdy@%0d", t),   int'(pix_rdy),   e_rdy);
    chk($sformatf("sa_en@%0d", t),     int'(sa_en),     e_sa);
    chk($sformatf("done@%0d", t),      int'(done),      e_done);
    chk($sformatf("win_row@%0d", t),   int'(win_row),   e_row);
    chk($sformatf("win_col@%0d", t),   int'(win_col),   e_col);
    chk($sformatf("err@%0d", t),       int'(err),       int'(err_m));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; abort = 1'b0; feed_srt = 1'b0;
      pix_vld = 1'($urandom_range(0, 1)); pix_data = 16'($urandom);
      @(negedge clk);
      chk_outputs(-1, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
    end
  endtask

  // d: feed_srt rises d cycles after ARM (0 = never); und: index of the
  // missing pixel (-1 none); abt: cycle of a one-cycle abort (-1 none);
  // rstt: cycle of an asynchronous reset pulse (-1 none); junk: extra starts.
  task automatic run_frame(input int d, input int und, input int abt, input int rstt, input bit junk);
    int fs, fe, done_t, t_u, kill, tend, k;
    int e_busy, e_load, e_rdy, e_sa, e_done, e_row, e_col;
    int cons, exp_cons, dn;
    bit alive;
    fs     = (d > 0) ? d + 1 : BIG;
    fe     = (d > 0) ? fs + NFEED - 1 : BIG;
    done_t = (d > 0) ? fe + DRN + 1 : BIG;
    t_u    = (und >= 0) ? 2 + und : BIG;
    kill   = (und >= 0) ? t_u + 1 : BIG;
    if (abt >= 0 && abt + 1 < kill) kill = abt + 1;
    if (rstt >= 0 && rstt < kill) kill = rstt;
    tend = (kill < BIG) ? kill + 2 : done_t + 2;
    cons = 0; exp_cons = 0; dn = 0;
    for (int t = 0; t <= tend; t++) begin
      start    = (t == 0) || (junk && t >= 1 && t <= done_t && $urandom_range(0, 3) == 0);
      abort    = (t == abt);
      feed_srt = (t >= fs) && (t <= fe);
      if (t >= 2 && t <= NPIX + 1) begin
        pix_vld  = (t != t_u);
        pix_data = 16'(t - 1);
      end else begin
        pix_vld  = 1'($urandom_range(0, 1));
        pix_data = 16'($urandom);
      end
      if (t == rstt) rst_n = 1'b0;
      @(negedge clk);
      alive  = (t < kill);
      e_busy = int'(alive && t >= 1 && t <= done_t);
      e_load = int'(alive && t >= 1 && t <= fe + DRN);
      e_rdy  = int'(alive && t >= 2 && t <= NPIX + 1);
      e_sa   = int'(alive && t >= fs && t <= fe + DRN);
      e_done = int'(alive && t == done_t);
      e_row  = 0; e_col = 0;
      if (alive && t >= fs && t <= fe) begin
        k = t - fs; e_row = k / SIZE; e_col = k % SIZE;
      end else if (alive && t > fe && t <= done_t) begin
        e_row = SIZE - 3; e_col = SIZE - 1;
      end
      if (t == rstt) err_m = 1'b0;
      else if (t == 1) err_m = 1'b0;
      if (t == t_u + 1) err_m = 1'b1;
      chk_outputs(t, e_busy, e_load, e_rdy, e_sa, e_done, e_row, e_col);
      chk($sformatf("feed_pix@%0d", t), int'(feed_pix), int'(pix_data));
      if (pix_vld && pix_rdy) cons++;
      if (e_rdy != 0 && pix_vld) exp_cons++;
      if (done) dn++;
      if (t == rstt) rst_n = 1'b1;
      @(posedge clk); #1;
      if (t == rstt) break;
    end
    start = 1'b0; abort = 1'b0; feed_srt = 1'b0; pix_vld = 1'b0;
    chk("pixels_consumed", cons, exp_cons);
    chk("done_pulses", dn, (kill == BIG) ? 1 : 0);
    done_total += dn;
  endtask

  initial begin
    int d;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_vld = 1'b0; feed_srt = 1'b0; pix_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs(-2, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(23, -1, -1, -1, 1'b0);
    idle_cycles(3);

    run_frame(0, 19, -1, -1, 1'b0);
    idle_cycles(2);

    d = $urandom_range(16, 40);
    run_frame(d, -1, -1, -1, 1'b0);
    idle_cycles(2);

    d = $urandom_range(16, 40);
    run_frame(d, -1, d + 1 + NFEED + 1, -1, 1'b0);
    idle_cycles(2);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    idle_cycles(3);

    d = $urandom_range(16, 40);
    run_frame(d, -1, -1, -1, 1'b1);
    idle_cycles(2);

    run_frame(23, -1, -1, 2 + 29, 1'b0);
    idle_cycles(2);
    d = $urandom_range(16, 40);
    run_frame(d, -1, -1, -1, 1'b0);
    idle_cycles(2);

    run_frame(0, 10, 12, -1, 1'b0);
    idle_cycles(2);

    chk("done_total", done_total, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_feed_ctrl.md
Name: conv_feed_ctrl

Overview:
- Frame-level sequencer for the 3-row image feeder in front of the systolic array (SA).
- On a host start it streams one SIZE x SIZE frame of 16-bit signed pixels from an upstream source into the feeder and holds the feeder's load level for the whole frame.
- It then times the feeder's column stream and the SA drain, publishes the current output-window coordinates, and reports done or error to the host.

Parameters:
- SIZE, 7, image height and width in pixels; legal range 3..255.
- DRAIN_CYC, 4, cycles the SA stays enabled after the last fed column.
- CNT_W, 16, width of the internal cycle counters; must hold SIZE*SIZE.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  host request; one-cycle pulse, sampled only in IDLE.
- abort  in  1  host soft-cancel; level, honoured in every state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  sticky underrun flag; cleared by the next accepted start.
- pix_vld  in  1  upstream pixel valid.
- pix_data  in  16  upstream pixel, signed, raster order.
- pix_rdy  out  1  controller accepts a pixel this cycle.
- feed_load  out  1  feeder load level.
- feed_pix  out  16  pixel to the feeder; combinational copy of pix_data.
- feed_srt  in  1  feeder start indication, high while columns are streaming.
- sa_en  out  1  SA compute enable.
- win_row  out  8  output-window row index, 0..SIZE-3.
- win_col  out  8  output-window column index, 0..SIZE-1.

Behaviour:
- Reset: state=IDLE; every output 0; all counters 0; err=0.
- IDLE -> ARM on start: clear err, assert feed_load.
  - ARM lasts exactly one cycle so the feeder can register the load.
  - pix_rdy stays 0 in ARM.
- ARM -> LOAD.
  - pix_rdy=1 for exactly SIZE*SIZE consecutive cycles.
  - Each cycle pix_vld must be 1; a pixel is consumed on pix_vld & pix_rdy.
  - pix_cnt increments on each consumed pixel.
  - pix_vld=0 while pix_rdy=1 is an underrun: set err, drop feed_load, drop pix_rdy, go to IDLE next cycle, no done pulse.
- Overlap with the feeder: feed_srt may rise while still in LOAD, once 3 rows are stored.
  - The feed counter runs independently of state, starting at the first cycle feed_srt=1 after ARM.
- LOAD -> WAIT_FEED when pix_cnt reaches SIZE*SIZE.
  - pix_rdy=0 from then on; feed_load stays 1.
- Feed counting (runs across LOAD, WAIT_FEED and FEED):
  - sa_en=1 from the first feed_srt=1 cycle.
  - feed_cnt counts (SIZE-2)*SIZE cycles.
  - win_col increments every counted cycle and wraps SIZE-1 -> 0, incrementing win_row on the wrap.
- Transition to DRAIN on the cycle feed_cnt reaches (SIZE-2)*SIZE.
  - Reached from WAIT_FEED directly, or via FEED if loading finished later.
- DRAIN: sa_en=1 for DRAIN_CYC more cycles; win_row and win_col hold their last values (SIZE-3, SIZE-1).
- DRAIN -> DONE.
  - DONE: feed_load=0, sa_en=0, done=1 for one cycle.
  - DONE -> IDLE; win_row and win_col return to 0.
- abort=1 in any state: go to IDLE next cycle.
  - All outputs drop to their reset values except err, which holds.
  - No done pulse.
- start is ignored while busy=1; start and abort together in IDLE: abort wins and the frame does not start.
- Simultaneous underrun and abort: abort path taken, but err is still set.
- Reset asserted mid-frame: immediate return to IDLE; feed_load and sa_en low asynchronously.
- Counter widths: feed_cnt and pix_cnt are CNT_W bits and saturate, never wrap.

Decomposition:
- Shared package conv_pkg holds:
  - the state enum (IDLE, ARM, LOAD, WAIT_FEED, FEED, DRAIN, DONE);
  - the PIX_W=16 constant;
  - the function npix(SIZE) = SIZE*SIZE;
  - the function nfeed(SIZE) = (SIZE-2)*SIZE.
- One natural sub-module, win_counter: a wrapping col/row counter with en, clr and a last flag, reused later by the result writer.

Test Plan:
- SIZE=7, start pulse, pix_vld held 1 with values 1..49:
  - feed_load high from the cycle after start until DONE;
  - pix_rdy high for exactly 49 cycles starting 2 cycles after start;
  - feed_pix tracks pix_data each cycle.
- Same frame with feed_srt driven high 23 cycles after ARM:
  - sa_en high for 35+4=39 cycles;
  - win_row/win_col step (0,0)..(4,6);
  - done single pulse exactly 4 cycles after feed_cnt hits 35.
- Underrun: pix_vld=0 on pixel 20:
  - err=1, feed_load=0 next cycle, no done;
  - next start clears err and a full frame completes.
- abort asserted during DRAIN: IDLE next cycle, sa_en=0, done never pulses, err unchanged (0).
- start pulses while busy, plus start+abort together in IDLE: no extra frame, busy stays consistent, done count = 1 for one real frame.
- rst_n pulled low mid-LOAD (pixel 30), then released:
  - all outputs 0 immediately;
  - a subsequent start runs a clean 49-pixel frame with correct window indices.
